// File: rtl/reg_arbiter.sv
// Two-port arbiter that serialises register-bank accesses. Each access is IDLE -> ISSUE (-> RESP for reads).
// Define ARB_FIXED_PRIO_EN to give port 0 fixed priority; by default ties go round-robin.
`timescale 1ns/1ps
module reg_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nxt;
  logic              pick;       // winning port index for this IDLE cycle
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic              port;       // port owning the in-flight transfer
  logic              is_wr;

`ifdef ARB_FIXED_PRIO_EN
  assign pick = ~req0;
`else
  logic last;                    // index of the most recently granted port
  assign pick = (req0 && req1) ? ~last : req1;
`endif

  assign pick_we    = pick ? we1    : we0;
  assign pick_addr  = pick ? addr1  : addr0;
  assign pick_wdata = pick ? wdata1 : wdata0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ISSUE;
      ISSUE:   state_nxt = is_wr ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      port       <= 1'b0;
      is_wr      <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      addr       <= '0;
      data_write <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last       <= 1'b1;
`endif
    end else begin
      state   <= state_nxt;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      read    <= 1'b0;
      write   <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          // Strobe goes out on the same edge the request is latched.
          port  <= pick;
          is_wr <= pick_we;
          addr  <= pick_addr;
          if (pick_we) data_write <= pick_wdata;
          read  <= ~pick_we;
          write <= pick_we;
          gnt0  <= ~pick;
          gnt1  <= pick;
`ifndef ARB_FIXED_PRIO_EN
          last  <= pick;
`endif
        end
        RESP: begin
          if (port) begin
            rdata1  <= data_read;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= data_read;
            rvalid0 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// Bench for reg_arbiter: directed vector table, corner-case sequences, then random traffic
// checked against a transaction-level model of the arbiter and the register bank.
`timescale 1ns/1ps
module tb_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [5:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, read, write;
  logic [7:0] rdata0, rdata1, data_write, data_read;
  logic [5:0] addr;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  reg_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .read(read), .write(write),
    .addr(addr), .data_write(data_write), .data_read(data_read)
  );

  // Register bank: contents reset to addr ^ 0x2E, so location 0x12 holds 0x3C.
  logic [7:0] bank [64];
  assign data_read = bank[addr];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) bank[i] <= 8'(i) ^ 8'h2E;
    end else if (write) begin
      bank[addr] <= data_write;
    end
  end

  logic [7:0] ref_mem [64];
  logic [7:0] exp_rd0, exp_rd1;

  typedef struct {
    logic r0; logic w0; logic [5:0] a0; logic [7:0] d0;
    logic r1; logic w1; logic [5:0] a1; logic [7:0] d1;
    logic eg0; logic eg1; logic erd; logic ewr; logic [5:0] ea; logic [7:0] ed;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [35:0] outs();
    return {gnt0, gnt1, read, write, rvalid0, rvalid1, addr, data_write, rdata0, rdata1};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic ref_init();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i) ^ 8'h2E;
    exp_rd0 = '0;
    exp_rd1 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    ref_init();
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    @(posedge clk); #1;
    chk($sformatf("v%0d_strobe", idx), {gnt0, gnt1, read, write}, {v.eg0, v.eg1, v.erd, v.ewr});
    chk($sformatf("v%0d_addr", idx), addr, v.ea);
    chk($sformatf("v%0d_dwrite", idx), data_write, v.ed);
    chk($sformatf("v%0d_rv_hold", idx), {rvalid0, rvalid1, rdata0, rdata1}, {2'b00, exp_rd0, exp_rd1});
    req0 = 1'b0; req1 = 1'b0;
    if (v.ewr) ref_mem[v.ea] = v.ed;
    @(posedge clk); #1;
    chk($sformatf("v%0d_quiet", idx), {gnt0, gnt1, read, write, rvalid0, rvalid1}, 0);
    if (v.erd) begin
      if (v.eg0) exp_rd0 = ref_mem[v.ea];
      else       exp_rd1 = ref_mem[v.ea];
      @(posedge clk); #1;
      chk($sformatf("v%0d_rvalid", idx), {gnt0, gnt1, read, write, rvalid0, rvalid1},
          {4'b0000, v.eg0, v.eg1});
      chk($sformatf("v%0d_rdata", idx), {rdata0, rdata1}, {exp_rd0, exp_rd1});
    end
  endtask

  task automatic rnd_port(input bit p);
    if (p) begin
      we1 = 1'($urandom_range(0, 1)); addr1 = 6'($urandom); wdata1 = 8'($urandom);
    end else begin
      we0 = 1'($urandom_range(0, 1)); addr0 = 6'($urandom); wdata0 = 8'($urandom);
    end
  endtask

  // Random-phase model state
  int         next_dec, rd_due;
  logic       rd_port, last_m, win, w;
  logic [5:0] a, m_addr;
  logic [7:0] d, m_dw, rd_val, m_rd0, m_rd1;
  logic       e_g0, e_g1, e_rd, e_wr, e_rv0, e_rv1;
  logic [1:0] exp_g;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 6'h05, 8'hA5, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 6'h05, 8'hA5};
    tbl[1] = '{1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 6'h12, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 6'h12, 8'hA5};
    tbl[2] = '{1'b1, 1'b1, 6'h0A, 8'h11, 1'b1, 1'b1, 6'h0B, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 6'h0A, 8'h11};
`ifdef ARB_FIXED_PRIO_EN
    tbl[3] = '{1'b1, 1'b0, 6'h0A, 8'h00, 1'b1, 1'b0, 6'h0B, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 6'h0A, 8'h11};
`else
    tbl[3] = '{1'b1, 1'b0, 6'h0A, 8'h00, 1'b1, 1'b0, 6'h0B, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 6'h0B, 8'h11};
`endif
    tbl[4] = '{1'b1, 1'b0, 6'h05, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 6'h05, 8'h11};
    tbl[5] = '{1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b1, 6'h3F, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 6'h3F, 8'hFF};
    tbl[6] = '{1'b1, 1'b0, 6'h3F, 8'h00, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 6'h3F, 8'hFF};

    do_reset();
    for (int i = 0; i < 7; i++) apply_vec(tbl[i], i);

    // Both ports streaming reads: one grant every 3 cycles, alternating (last grant was port 0).
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h05;
    req1 = 1'b1; we1 = 1'b0; addr1 = 6'h3F;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
`ifdef ARB_FIXED_PRIO_EN
      exp_g = (c % 3 == 0) ? 2'b10 : 2'b00;
`else
      exp_g = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
`endif
      chk($sformatf("alt_c%0d", c), {gnt0, gnt1}, exp_g);
    end
    req0 = 1'b0; req1 = 1'b0;
    if (exp_rd0 == exp_rd0) exp_rd0 = ref_mem[6'h05];
    exp_rd1 = ref_mem[6'h3F];

    // Port-1 request raised during a port-0 read's RESP cycle.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h05;
    @(posedge clk); #1;
    chk("late_gnt0", {gnt0, gnt1, read, write}, 4'b1010);
    req0 = 1'b0;
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'h20; wdata1 = 8'h77;
    @(posedge clk); #1;
    chk("late_rvalid0", {gnt0, gnt1, read, write, rvalid0, rvalid1}, 6'b000010);
    chk("late_rdata0", rdata0, ref_mem[6'h05]);
    @(posedge clk); #1;
    chk("late_gnt1", {gnt0, gnt1, read, write, rvalid0, rvalid1}, 6'b010100);
    chk("late_addr", {addr, data_write}, {6'h20, 8'h77});
    req1 = 1'b0;
    @(posedge clk); #1;

    // Reset asserted during RESP of a read: response dropped, everything cleared.
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h3F;
    @(posedge clk); #1;
    chk("rst_gnt0", {gnt0, read}, 2'b11);
    req0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_resp", outs(), 0);
    rst_n = 1'b1;
    ref_init();
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'h01; wdata0 = 8'h5A;
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'h02; wdata1 = 8'h66;
    @(posedge clk); #1;
    chk("rst_regrant", {gnt0, gnt1, read, write, rvalid0, rvalid1}, 6'b100100);
    chk("rst_regrant_bus", {addr, data_write}, {6'h01, 8'h5A});
    req0 = 1'b0; req1 = 1'b0;
    ref_mem[6'h01] = 8'h5A;
    @(posedge clk); #1;

    // req0 dropped during ISSUE: transfer completes, no second grant.
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'h01;
    @(posedge clk); #1;
    chk("drop_gnt", {gnt0, gnt1, read, write}, 4'b1010);
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("drop_resp", {gnt0, gnt1, read, write, rvalid0, rvalid1}, 0);
    @(posedge clk); #1;
    chk("drop_rvalid", {gnt0, gnt1, rvalid0, rvalid1, rdata0}, {4'b0010, 8'h5A});
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("drop_no_regrant", {gnt0, gnt1, read, write, rvalid0, rvalid1}, 0);
    end

    // Random traffic against a transaction-level model.
    do_reset();
    next_dec = 0; rd_due = -10; last_m = 1'b1; rd_port = 1'b0; rd_val = '0;
    m_addr = '0; m_dw = '0; m_rd0 = '0; m_rd1 = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      e_g0 = 1'b0; e_g1 = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
      if (cyc >= next_dec && (req0 || req1)) begin
`ifdef ARB_FIXED_PRIO_EN
        win = req0 ? 1'b0 : 1'b1;
`else
        if (req0 && req1) win = (last_m == 1'b0);
        else              win = req0 ? 1'b0 : 1'b1;
`endif
        w = win ? we1 : we0;
        a = win ? addr1 : addr0;
        d = win ? wdata1 : wdata0;
        if (win) e_g1 = 1'b1; else e_g0 = 1'b1;
        m_addr = a;
        if (w) begin
          e_wr = 1'b1; m_dw = d; ref_mem[a] = d; next_dec = cyc + 2;
        end else begin
          e_rd = 1'b1; rd_due = cyc + 2; rd_port = win; rd_val = ref_mem[a]; next_dec = cyc + 3;
        end
        last_m = win;
      end
      if (cyc == rd_due) begin
        if (rd_port) begin e_rv1 = 1'b1; m_rd1 = rd_val; end
        else         begin e_rv0 = 1'b1; m_rd0 = rd_val; end
      end
      @(posedge clk); #1;
      chk($sformatf("rand_c%0d", cyc), outs(),
          {e_g0, e_g1, e_rd, e_wr, e_rv0, e_rv1, m_addr, m_dw, m_rd0, m_rd1});
      if (e_g0) begin
        if ($urandom_range(0, 3) == 0) rnd_port(1'b0); else req0 = 1'b0;
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; rnd_port(1'b0);
      end
      if (e_g1) begin
        if ($urandom_range(0, 3) == 0) rnd_port(1'b1); else req1 = 1'b0;
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; rnd_port(1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
# reg_arbiter

Two-port arbiter that shares the peripheral register-bank access bus (read/write/addr/data_write/data_read) between the SPI instruction decoder and a second, internal requester, such as a PWM status/auto-reload sequencer. It serialises requests, issues single-cycle read/write strobes to the register bank, and returns read data to the winning port. It sits between the requesters and the register bank in the peripheral clock domain.

## Interface
- `ADDR_W`, default 6: register address width.
- `DATA_W`, default 8: register data width.

Ports:
- `clk`  in  1  peripheral clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req0`, `req1`  in  1 each  transfer request, held high until `gnt` is seen.
- `we0`, `we1`  in  1 each  1 = write, 0 = read; valid while `req` is high.
- `addr0`, `addr1`  in  ADDR_W each  target register.
- `wdata0`, `wdata1`  in  DATA_W each  write data.
- `gnt0`, `gnt1`  out  1 each  one-cycle pulse, asserted with the bus strobe.
- `rdata0`, `rdata1`  out  DATA_W each  read result, held until the next read on that port.
- `rvalid0`, `rvalid1`  out  1 each  one-cycle pulse when `rdata` updates.
- `read`  out  1  register-bank read strobe.
- `write`  out  1  register-bank write strobe.
- `addr`  out  ADDR_W  register-bank address.
- `data_write`  out  DATA_W  register-bank write data.
- `data_read`  in  DATA_W  register-bank read data.

## Operation
- All outputs are registered. Reset value of every output is 0. The arbiter returns to IDLE, and the round-robin pointer is set to "port 1 last granted", so port 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if any `req` is sampled high, select the winner, latch its `we`/`addr`/`wdata`, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: this is the single cycle in which `read` or `write` is high, together with `gnt` of the winner. On a write, go to IDLE. On a read, go to RESP.
  - RESP: sample `data_read` into the winner's `rdata` and pulse its `rvalid` in the following cycle. Then go to IDLE.
- Arbitration (default round-robin):
  - If only one port requests, it wins.
  - If both request, the port not granted last wins.
  - The pointer updates on every grant.
- `addr` and `data_write` keep their last values between transfers. `data_write` updates only on writes.
- `req` changes after the winner's request is latched (ISSUE/RESP) are ignored; the latched transaction completes.
- A `req` raised while the FSM is busy waits and is evaluated in the next IDLE cycle.
- The FSM never drives `read` and `write` high in the same cycle, and never drives both `gnt` signals high in the same cycle.
- A requester that keeps `req` high after its `gnt` requests another transfer.
- Synchronous reset mid-transfer:
  - All strobes, `gnt` and `rvalid` are 0 at the next edge.
  - An in-flight read is dropped, with no `rvalid`.
  - `rdata0`/`rdata1` clear to 0.

## Timing
- `req` sampled at edge E0 (IDLE) results in:
  - strobe, `addr` and `gnt` high during cycle E0–E1;
  - for a read, `data_read` sampled at E2;
  - `rvalid` and new `rdata` during cycle E2–E3.
- Write throughput: one transfer per 2 cycles. Read throughput: one per 3 cycles.
- The register bank must present `data_read` for the strobed `addr` by the edge after the strobe cycle. `addr` is held stable through RESP.
- Worst-case wait for a requesting port under round-robin is one full competing transfer (3 cycles) plus its own.

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. Port 0 (SPI decoder) always wins a tie, the round-robin pointer is removed, and port 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then `req0`=1, `we0`=1, `addr0`=6'h05, `wdata0`=8'hA5 → one cycle later `write`=1, `addr`=05, `data_write`=A5, `gnt0`=1 for exactly 1 cycle; all other outputs 0.
- `req1` read of `addr1`=6'h12, bank returns 8'h3C → `read` pulse with `gnt1`, then `rvalid1`=1 and `rdata1`=3C two cycles after the strobe; `rdata0` unchanged.
- `req0` and `req1` both held high with reads → grants alternate 0,1,0,1 with 3-cycle spacing. With `ARB_FIXED_PRIO_EN` defined, `gnt0` only.
- `req1` raised during a port-0 read's RESP cycle → `req1` served in the strobe slot immediately after the port-0 read returns to IDLE; port-0 `rvalid0` is still delivered.
- `rst_n`=0 asserted in the RESP cycle of a read → no `rvalid`; all outputs 0 at the next edge; after release, a new `req0` is granted with normal latency.
- `req0` dropped during its ISSUE cycle → the transfer still completes (`rvalid0` for a read), and no second grant is issued.
